// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and a width helper.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SHR = 4'd2;
    localparam logic [3:0] OP_SHL = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Smallest n with 2**n >= value; sizes the iteration counter.
    function automatic int clog2(input int value);
        int n;
        n = 0;
        while ((1 << n) < value) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU; master = producer/consumer side, slave = ALU.
interface alu_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic             op_err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, op_err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, op_err
    );
endinterface

// File: rtl/alu_seq_iter.sv
// Iterative shift-add multiplier and (with ALU_SEQ_DIV_EN) restoring divider, one bit per cycle.
// done pulses in the cycle of the last iteration with res/carry already reflecting that step.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             carry
);
    localparam int CNT_W = clog2(WIDTH + 1);

    logic                   busy_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [2*WIDTH-1:0]     prod_reg;
    logic [2*WIDTH-1:0]     prod_next;
    logic [2*WIDTH-1:0]     prod_mul_next;
    logic [WIDTH-1:0]       opb_reg;
    logic [WIDTH:0]         mul_sum;

    // Multiplier: low half holds the multiplier, consumed LSB first as the product shifts in.
    always_comb begin
        mul_sum       = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, opb_reg} : '0);
        prod_mul_next = {mul_sum, prod_reg[WIDTH-1:1]};
    end

    assign done = busy_reg && (cnt_reg == CNT_W'(WIDTH - 1));

`ifdef ALU_SEQ_DIV_EN
    logic             is_div_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             fits;

    // Low half of prod_reg doubles as the dividend/quotient shift register. A zero divisor
    // always "fits", which yields the all-ones quotient without a special case.
    always_comb begin
        rem_shift = {rem_reg, prod_reg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opb_reg};
        fits      = ~rem_diff[WIDTH];
        rem_next  = fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {prod_reg[WIDTH-2:0], fits};
    end

    assign prod_next = is_div_reg ? {{WIDTH{1'b0}}, quo_next} : prod_mul_next;
    assign res       = is_div_reg ? quo_next : prod_mul_next[WIDTH-1:0];
    assign carry     = is_div_reg ? (opb_reg == '0) : (|prod_mul_next[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk) begin
        if (rst) begin
            is_div_reg <= 1'b0;
            rem_reg    <= '0;
        end else if (start) begin
            is_div_reg <= is_div;
            rem_reg    <= '0;
        end else if (busy_reg) begin
            rem_reg    <= rem_next;
        end
    end
`else
    logic unused_div;
    assign unused_div = is_div;
    assign prod_next  = prod_mul_next;
    assign res        = prod_mul_next[WIDTH-1:0];
    assign carry      = |prod_mul_next[2*WIDTH-1:WIDTH];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
            prod_reg <= '0;
            opb_reg  <= '0;
        end else if (start) begin
            busy_reg <= 1'b1;
            cnt_reg  <= '0;
            prod_reg <= {{WIDTH{1'b0}}, a};
            opb_reg  <= b;
        end else if (busy_reg) begin
            prod_reg <= prod_next;
            cnt_reg  <= cnt_reg + CNT_W'(1);
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, C/Z/N/V flags and iterative MUL (and DIV when
// ALU_SEQ_DIV_EN is defined; otherwise op 9 reports op_err like any illegal op).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             accept;
    logic             is_multi;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic [WIDTH-1:0] xor_bits;
    logic [WIDTH-1:0] not_bits;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_err;

    logic             iter_done;
    logic [WIDTH-1:0] iter_res;
    logic             iter_carry;

    logic [WIDTH-1:0] result_reg;
    logic             c_reg;
    logic             z_reg;
    logic             n_reg;
    logic             v_reg;
    logic             err_reg;

    assign opa    = bus.a;
    assign opb    = bus.b;
    assign accept = bus.in_valid && bus.in_ready;

`ifdef ALU_SEQ_DIV_EN
    assign is_multi = (bus.op == OP_MUL) || (bus.op == OP_DIV);
`else
    assign is_multi = (bus.op == OP_MUL);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign and_bits[gi] = opa[gi] & opb[gi];
            assign or_bits[gi]  = opa[gi] | opb[gi];
            assign xor_bits[gi] = opa[gi] ^ opb[gi];
            assign not_bits[gi] = ~opa[gi];
        end
    endgenerate

    // Single-cycle ops; MUL/DIV fall into the default arm but are never captured from here.
    always_comb begin
        sum_ext = {1'b0, opa} + {1'b0, opb};
        diff    = opa - opb;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum_ext[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_c   = (opa >= opb);
                alu_v   = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SHR: begin
                alu_res = {1'b0, opa[WIDTH-1:1]};
                alu_c   = opa[0];
            end
            OP_SHL: begin
                alu_res = {opa[WIDTH-2:0], 1'b0};
                alu_c   = opa[WIDTH-1];
            end
            OP_AND:  alu_res = and_bits;
            OP_OR:   alu_res = or_bits;
            OP_NOT:  alu_res = not_bits;
            OP_XOR:  alu_res = xor_bits;
            default: alu_err = 1'b1;
        endcase
    end

    alu_seq_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_multi),
        .is_div (bus.op == OP_DIV),
        .a      (opa),
        .b      (opb),
        .done   (iter_done),
        .res    (iter_res),
        .carry  (iter_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = is_multi ? S_BUSY : S_DONE;
            S_BUSY: if (iter_done) state_next = S_DONE;
            S_DONE: if (bus.out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_reg == S_IDLE);
        bus.out_valid = (state_reg == S_DONE);
    end

    // Result/flags change only on capture, so they hold steady for the whole DONE phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg <= '0;
            c_reg      <= 1'b0;
            z_reg      <= 1'b0;
            n_reg      <= 1'b0;
            v_reg      <= 1'b0;
            err_reg    <= 1'b0;
        end else if (accept && !is_multi) begin
            result_reg <= alu_res;
            c_reg      <= alu_c;
            z_reg      <= (alu_res == '0);
            n_reg      <= alu_res[WIDTH-1];
            v_reg      <= alu_v;
            err_reg    <= alu_err;
        end else if (iter_done) begin
            result_reg <= iter_res;
            c_reg      <= iter_carry;
            z_reg      <= (iter_res == '0);
            n_reg      <= iter_res[WIDTH-1];
            v_reg      <= 1'b0;
            err_reg    <= 1'b0;
        end
    end

    assign bus.result = result_reg;
    assign bus.flag_c = c_reg;
    assign bus.flag_z = z_reg;
    assign bus.flag_n = n_reg;
    assign bus.flag_v = v_reg;
    assign bus.op_err = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): directed vector table, handshake corner sequences and random
// ops against an arithmetic reference model. Follows ALU_SEQ_DIV_EN like the design.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 16;
    localparam int MULTI_LAT = W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] r;
        logic        c, z, n, v, e;
        int          lat;
        logic        ready_low;
        logic        stable;
    } obs_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b;
        logic [15:0] r;
        logic        c, z, n, v, e;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Present one op, wait for the result, optionally hold out_ready low, then complete it.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int hold, output obs_t o);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = 1'b0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom);
        bus.a  = 16'($urandom);
        bus.b  = 16'($urandom);
        o.lat = 1;
        o.ready_low = 1'b1;
        while (!bus.out_valid && o.lat < 100) begin
            if (bus.in_ready) o.ready_low = 1'b0;
            @(negedge clk);
            o.lat++;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
        end
        o.r = bus.result;
        o.c = bus.flag_c;
        o.z = bus.flag_z;
        o.n = bus.flag_n;
        o.v = bus.flag_v;
        o.e = bus.op_err;
        o.stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (bus.result !== o.r || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                o.stable = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        $display("op=%0d a=%04h b=%04h -> r=%04h c=%0b z=%0b n=%0b v=%0b err=%0b lat=%0d",
                 op, a, b, o.r, o.c, o.z, o.n, o.v, o.e, o.lat);
    endtask

    task automatic check_obs(input string tag, input obs_t o, input logic [15:0] r,
                             input logic c, input logic z, input logic n, input logic v,
                             input logic e, input int lat);
        check({tag, ".result"}, {16'd0, o.r}, {16'd0, r});
        check({tag, ".c"}, {31'd0, o.c}, {31'd0, c});
        check({tag, ".z"}, {31'd0, o.z}, {31'd0, z});
        check({tag, ".n"}, {31'd0, o.n}, {31'd0, n});
        check({tag, ".v"}, {31'd0, o.v}, {31'd0, v});
        check({tag, ".op_err"}, {31'd0, o.e}, {31'd0, e});
        check({tag, ".latency"}, lat, o.lat);
        check({tag, ".ready_low"}, {31'd0, o.ready_low}, 32'd1);
        check({tag, ".hold_stable"}, {31'd0, o.stable}, 32'd1);
    endtask

    // Reference model: integer arithmetic straight from the op definitions.
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic c, output logic v,
                         output logic e, output int lat);
        longint ua, ub, full;
        int sa, sb, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        full = 0;
        c = 1'b0;
        v = 1'b0;
        e = 1'b0;
        lat = 1;
        case (op)
            4'd0: begin full = ua + ub; c = (full > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
            4'd1: begin full = ua - ub; c = (ua >= ub); sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
            4'd2: begin full = ua / 2; c = (ua % 2) == 1; end
            4'd3: begin full = ua * 2; c = (ua >= 32768); end
            4'd4: full = longint'(a & b);
            4'd5: full = longint'(a | b);
            4'd6: full = 65535 - ua;
            4'd7: full = longint'(a ^ b);
            4'd8: begin full = ua * ub; c = (full / 65536) != 0; lat = MULTI_LAT; end
            4'd9: begin
`ifdef ALU_SEQ_DIV_EN
                if (ub == 0) begin full = 65535; c = 1'b1; end
                else full = ua / ub;
                lat = MULTI_LAT;
`else
                e = 1'b1;
`endif
            end
            default: e = 1'b1;
        endcase
        full = full % 65536;
        if (full < 0) full = full + 65536;
        r = 16'(full);
    endtask

    initial begin
        obs_t o;
        logic [15:0] er;
        logic ec, ev, ee;
        int elat;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 4'd0;
        bus.a         = 16'd0;
        bus.b         = 16'd0;

        repeat (3) @(negedge clk);
        check("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset.result", {16'd0, bus.result}, 32'd0);
        check("reset.flags", {27'd0, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v, bus.op_err}, 32'd0);
        rst = 1'b0;

        // op, a, b, result, c, z, n, v, err, latency
        vecs.push_back('{4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1});
        vecs.push_back('{4'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'd2, 16'h0003, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd3, 16'h8001, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd6, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd7, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd12, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{4'd8, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 17});
        vecs.push_back('{4'd8, 16'd300, 16'd200, 16'hEA60, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 17});
`ifdef ALU_SEQ_DIV_EN
        vecs.push_back('{4'd9, 16'd100, 16'd7, 16'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17});
        vecs.push_back('{4'd9, 16'd5, 16'd0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17});
`else
        vecs.push_back('{4'd9, 16'd100, 16'd7, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{4'd9, 16'd5, 16'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1});
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, o);
            check_obs($sformatf("vec%0d", i), o, vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].n,
                      vecs[i].v, vecs[i].e, vecs[i].lat);
        end

        // Backpressure: XOR result must hold while a competing request is presented.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 4'd7; bus.a = 16'hF0F0; bus.b = 16'h0FF0;
        check("bp.accept_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.op = 4'd0; bus.a = 16'h0001; bus.b = 16'h0001;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp.result%0d", k), {16'd0, bus.result}, 32'h0000FF00);
            check($sformatf("bp.out_valid%0d", k), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("bp.in_ready%0d", k), {31'd0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp.after.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("bp.after.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("bp.after.result", {16'd0, bus.result}, 32'h0000FF00);
        $display("backpressure sequence: XOR F0F0^0FF0 held 5 cycles");

        // Reset in the middle of a multiply, then a fresh ADD.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 4'd8; bus.a = 16'd300; bus.b = 16'd200;
        check("mrst.accept_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mrst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mrst.result", {16'd0, bus.result}, 32'd0);
        check("mrst.flags", {27'd0, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v, bus.op_err}, 32'd0);
        $display("mid-multiply reset sequence applied");
        run_op(4'd0, 16'd2, 16'd2, 0, o);
        check_obs("mrst.add", o, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        // Random ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  rop;
            logic [15:0] ra, rb;
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 20));
            model(rop, ra, rb, er, ec, ev, ee, elat);
            run_op(rop, ra, rb, $urandom_range(0, 2), o);
            check_obs($sformatf("rnd%0d", i), o, er, ec, (er == 16'd0), er[15], ev, ee, elat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
